// File: rtl/line_seg_sequencer_if.sv
// Command handshake between the host/decoder and the segment sequencer.
// Targets are absolute signed points; abort flushes the queue.
interface line_seg_sequencer_if #(
  parameter int W = 16
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic signed [W-1:0] cmd_x;
  logic signed [W-1:0] cmd_y;
  logic                abort;

  modport master (
    output cmd_valid, cmd_x, cmd_y, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, abort,
    output cmd_ready
  );
endinterface

// File: rtl/line_seg_sequencer.sv
// Segment scheduler: queues absolute targets, launches the line
// interpolator once per segment and integrates its steps into position.
module line_seg_sequencer #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 140000
) (
  input  logic                pulse_clk,
  input  logic                sys_rst_l,
  line_seg_sequencer_if.slave cmd,
  output logic signed [W-1:0] Xe,
  output logic signed [W-1:0] Ye,
  output logic                change_readyH,
  input  logic                X_acc,
  input  logic                Y_acc,
  input  logic                X_dec,
  input  logic                Y_dec,
  input  logic                draw_overH,
  output logic signed [W-1:0] pos_x,
  output logic signed [W-1:0] pos_y,
  output logic                busy,
  output logic                seg_done,
  output logic                err_range,
  output logic                err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*W-1:0]      mem [DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [CW-1:0]       count;
  logic [TW-1:0]       wd;
  logic                ready_en;
  logic                push, pop, flush;
  logic                wd_hit, launch, seg_set, rng_set;
  logic signed [W-1:0] head_x, head_y;
  logic signed [W:0]   dx, dy;
  logic                ovf, zero;
  logic [W-1:0]        step_x, step_y;

  assign head_x = mem[rptr][2*W-1:W];
  assign head_y = mem[rptr][W-1:0];

  // One extra bit so the subtraction itself never wraps
  assign dx = {head_x[W-1], head_x} - {pos_x[W-1], pos_x};
  assign dy = {head_y[W-1], head_y} - {pos_y[W-1], pos_y};
  assign ovf  = (dx[W] ^ dx[W-1]) | (dy[W] ^ dy[W-1]);
  assign zero = (dx == '0) && (dy == '0);

  assign cmd.cmd_ready = ready_en
                       & (count != CW'(DEPTH))
                       & ~cmd.abort;

  assign push  = cmd.cmd_valid & cmd.cmd_ready & ~wd_hit;
  assign pop   = (state_q == S_LOAD);
  assign flush = cmd.abort | wd_hit;

  assign change_readyH = (state_q == S_ISSUE);
  assign busy = (state_q != S_IDLE) || (count != '0);

  always_comb begin
    state_d = state_q;
    wd_hit  = 1'b0;
    launch  = 1'b0;
    seg_set = 1'b0;
    rng_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count != '0 && !cmd.abort) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_IDLE;
        if (!cmd.abort) begin
          if (ovf) begin
            rng_set = 1'b1;
            seg_set = 1'b1;
          end else if (zero) begin
            seg_set = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (draw_overH) begin
          seg_set = 1'b1;
          state_d = S_DONE;
        end else if (wd == TW'(TIMEOUT - 1)) begin
          wd_hit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_x = '0;
    unique case (1'b1)
      X_acc & ~X_dec: step_x = W'(1);
      X_dec & ~X_acc: step_x = '1;
      default:        step_x = '0;
    endcase
  end

  always_comb begin
    step_y = '0;
    unique case (1'b1)
      Y_acc & ~Y_dec: step_y = W'(1);
      Y_dec & ~Y_acc: step_y = '1;
      default:        step_y = '0;
    endcase
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        rptr  <= wptr;
        count <= '0;
      end else begin
        if (push) begin
          mem[wptr] <= {cmd.cmd_x, cmd.cmd_y};
          wptr      <= wptr + AW'(1);
        end
        if (pop) rptr <= rptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      Xe          <= '0;
      Ye          <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      wd          <= '0;
      seg_done    <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pos_x       <= pos_x + step_x;
      pos_y       <= pos_y + step_y;
      seg_done    <= seg_set;
      err_range   <= err_range | rng_set;
      err_timeout <= err_timeout | wd_hit;
      if (launch) begin
        Xe <= dx[W-1:0];
        Ye <= dy[W-1:0];
      end
      if (state_q == S_ISSUE) begin
        wd <= '0;
      end else if (state_q == S_WAIT) begin
        wd <= wd + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_line_seg_sequencer.sv
// Directed bench for line_seg_sequencer with a behavioural
// interpolator that emits |Xe|+|Ye| steps and then draw_overH.
module tb_line_seg_sequencer;
  localparam int W = 16;

  logic pulse_clk = 1'b0;
  logic sys_rst_l = 1'b0;
  always #5 pulse_clk = ~pulse_clk;

  line_seg_sequencer_if #(.W(W)) cmd_if ();

  logic signed [W-1:0] Xe, Ye, pos_x, pos_y;
  logic change_readyH, busy, seg_done;
  logic err_range, err_timeout;
  logic X_acc, Y_acc, X_dec, Y_dec, draw_overH;

  logic m_xa = 0, m_xd = 0, m_ya = 0, m_yd = 0;
  logic m_do = 0;
  logic h_xa = 0, h_xd = 0;
  logic stub = 0;

  assign X_acc = m_xa | h_xa;
  assign X_dec = m_xd | h_xd;
  assign Y_acc = m_ya;
  assign Y_dec = m_yd;
  assign draw_overH = m_do;

  line_seg_sequencer #(
    .W(W), .DEPTH(4), .TIMEOUT(50)
  ) dut (
    .pulse_clk    (pulse_clk),
    .sys_rst_l    (sys_rst_l),
    .cmd          (cmd_if),
    .Xe           (Xe),
    .Ye           (Ye),
    .change_readyH(change_readyH),
    .X_acc        (X_acc),
    .Y_acc        (Y_acc),
    .X_dec        (X_dec),
    .Y_dec        (Y_dec),
    .draw_overH   (draw_overH),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .busy         (busy),
    .seg_done     (seg_done),
    .err_range    (err_range),
    .err_timeout  (err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cr_count, sd_count, steps;
  int cr_cyc, last_do, push_cyc;
  bit do_seen, ready_low_seen;
  int lx[$], ly[$], gaps[$];

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge pulse_clk) cyc++;

  always @(negedge pulse_clk) begin
    if (change_readyH) begin
      cr_count++;
      cr_cyc = cyc;
      if (do_seen) gaps.push_back(cyc - last_do);
    end
    if (draw_overH) begin
      last_do = cyc;
      do_seen = 1'b1;
    end
    if (seg_done) sd_count++;
    if (m_xa | m_xd) steps++;
    if (m_ya | m_yd) steps++;
  end

  // Interpolator model: latches Xe/Ye on launch, steps X then Y
  initial begin
    int ex, ey;
    forever begin
      @(posedge pulse_clk); #1;
      if (change_readyH) begin
        ex = int'(Xe);
        ey = int'(Ye);
        lx.push_back(ex);
        ly.push_back(ey);
        if (!stub) begin
          @(posedge pulse_clk); #1;
          for (int i = 0; i < (ex < 0 ? -ex : ex); i++) begin
            m_xa = (ex > 0);
            m_xd = (ex < 0);
            @(posedge pulse_clk); #1;
          end
          m_xa = 0; m_xd = 0;
          for (int i = 0; i < (ey < 0 ? -ey : ey); i++) begin
            m_ya = (ey > 0);
            m_yd = (ey < 0);
            @(posedge pulse_clk); #1;
          end
          m_ya = 0; m_yd = 0;
          m_do = 1;
          @(posedge pulse_clk); #1;
          m_do = 0;
        end
      end
    end
  end

  task automatic clear_logs();
    cr_count = 0;
    sd_count = 0;
    steps = 0;
    do_seen = 0;
    ready_low_seen = 0;
    lx.delete();
    ly.delete();
    gaps.delete();
  endtask

  task automatic do_reset();
    @(negedge pulse_clk);
    sys_rst_l = 0;
    repeat (2) @(negedge pulse_clk);
    clear_logs();
    sys_rst_l = 1;
    repeat (2) @(negedge pulse_clk);
  endtask

  task automatic push(input int x, input int y);
    int n = 0;
    cmd_if.cmd_valid = 1;
    cmd_if.cmd_x = W'(x);
    cmd_if.cmd_y = W'(y);
    while (!cmd_if.cmd_ready && n < 200) begin
      ready_low_seen = 1;
      @(negedge pulse_clk);
      n++;
    end
    if (n >= 200) check("push_ready", cmd_if.cmd_ready, 1);
    push_cyc = cyc;
    @(negedge pulse_clk);
    cmd_if.cmd_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge pulse_clk);
      n++;
    end
    check(tag, busy, 0);
    repeat (3) @(negedge pulse_clk);
  endtask

  initial begin
    int n, t;
    cmd_if.cmd_valid = 0;
    cmd_if.cmd_x = '0;
    cmd_if.cmd_y = '0;
    cmd_if.abort = 0;
    clear_logs();

    // Reset values
    repeat (2) @(negedge pulse_clk);
    check("rst_ready", cmd_if.cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cr", change_readyH, 0);
    check("rst_pos", {pos_x, pos_y}, 0);
    check("rst_xeye", {Xe, Ye}, 0);
    check("rst_err", {err_range, err_timeout, seg_done}, 0);
    sys_rst_l = 1;
    @(negedge pulse_clk);
    check("ready_after_rst", cmd_if.cmd_ready, 1);

    // Single segment
    do_reset();
    push(5, 3);
    wait_idle("single_idle");
    check("single_lat", cr_cyc - push_cyc, 3);
    check("single_launch", cr_count, 1);
    check("single_xe", lx[0], 5);
    check("single_ye", ly[0], 3);
    check("single_steps", steps, 8);
    check("single_posx", pos_x, 5);
    check("single_posy", pos_y, 3);
    check("single_done", sd_count, 1);

    // Polyline
    do_reset();
    push(4, -2);
    push(-1, -2);
    push(0, 0);
    wait_idle("poly_idle");
    check("poly_launch", cr_count, 3);
    check("poly_xe0", lx[0], 4);
    check("poly_ye0", ly[0], -2);
    check("poly_xe1", lx[1], -5);
    check("poly_ye1", ly[1], 0);
    check("poly_xe2", lx[2], 1);
    check("poly_ye2", ly[2], 2);
    check("poly_pos", {pos_x, pos_y}, 0);
    check("poly_done", sd_count, 3);
    check("poly_ngap", gaps.size(), 2);
    check("poly_gap0", gaps[0], 4);
    check("poly_gap1", gaps[1], 4);

    // Zero segment, range overflow, acc+dec cancel
    do_reset();
    push(0, 0);
    wait_idle("zero_idle");
    check("zero_done", sd_count, 1);
    check("zero_launch", cr_count, 0);
    h_xd = 1;
    repeat (30000) @(negedge pulse_clk);
    h_xd = 0;
    @(negedge pulse_clk);
    check("move_posx", pos_x, -30000);
    push(30000, 0);
    wait_idle("ovf_idle");
    check("ovf_err", err_range, 1);
    check("ovf_launch", cr_count, 0);
    check("ovf_done", sd_count, 2);
    check("ovf_posx", pos_x, -30000);
    check("ovf_posy", pos_y, 0);
    h_xa = 1;
    h_xd = 1;
    @(negedge pulse_clk);
    h_xa = 0;
    h_xd = 0;
    @(negedge pulse_clk);
    check("cancel_posx", pos_x, -30000);
    check("ovf_sticky", err_range, 1);

    // Backpressure
    do_reset();
    for (int i = 1; i <= 6; i++) push(10 * i, 0);
    wait_idle("bp_idle");
    check("bp_ready_low", ready_low_seen, 1);
    check("bp_launch", cr_count, 6);
    check("bp_nlog", lx.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("bp_xe", lx[i], 10);
      check("bp_ye", ly[i], 0);
    end
    check("bp_posx", pos_x, 60);
    check("bp_done", sd_count, 6);

    // Abort during the first segment
    do_reset();
    push(3, 0);
    push(6, 0);
    push(9, 0);
    n = 0;
    while (cr_count < 1 && n < 100) begin
      @(negedge pulse_clk);
      n++;
    end
    @(negedge pulse_clk);
    cmd_if.abort = 1;
    #1;
    check("abort_ready", cmd_if.cmd_ready, 0);
    @(negedge pulse_clk);
    cmd_if.abort = 0;
    wait_idle("abort_idle");
    check("abort_launch", cr_count, 1);
    check("abort_posx", pos_x, 3);
    check("abort_done", sd_count, 1);

    // Watchdog with a stuck interpolator
    stub = 1;
    do_reset();
    push(2, 0);
    push(4, 0);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge pulse_clk);
      n++;
    end
    t = cyc;
    check("wd_err", err_timeout, 1);
    check("wd_lat", t - cr_cyc, 51);
    wait_idle("wd_idle");
    check("wd_launch", cr_count, 1);
    check("wd_done", sd_count, 0);
    check("wd_pos", {pos_x, pos_y}, 0);
    stub = 0;
    repeat (4) @(negedge pulse_clk);

    // Asynchronous reset mid-segment
    do_reset();
    push(8, 0);
    n = 0;
    while (cr_count < 1 && n < 100) begin
      @(negedge pulse_clk);
      n++;
    end
    repeat (4) @(negedge pulse_clk);
    check("mid_posx_moving", pos_x != 0, 1);
    #2;
    sys_rst_l = 0;
    #1;
    check("arst_pos", {pos_x, pos_y}, 0);
    check("arst_busy", busy, 0);
    check("arst_xe", Xe, 0);
    repeat (12) @(negedge pulse_clk);
    sys_rst_l = 1;
    repeat (2) @(negedge pulse_clk);
    check("arst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
